// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg: shared state encoding and grant identifiers for shift_seq_arbiter.
package shift_seq_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic GRANT_REQ0 = 1'b0;
  localparam logic GRANT_REQ1 = 1'b1;
endpackage

// File: rtl/shift_seq_arbiter_piso_shifter.sv
// piso_shifter: parallel-load, enable-gated left shift register with MSB serial out.
module piso_shifter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  output logic             sout
);
  logic [WIDTH-1:0] shreg;
  always_ff @(posedge clk or posedge rst)
    if (rst) shreg <= '0;
    else if (load) shreg <= data;
    else if (en) shreg <= {shreg[WIDTH-2:0], 1'b0};
  assign sout = shreg[WIDTH-1];
endmodule

// File: rtl/shift_seq_arbiter.sv
// shift_seq_arbiter: round-robin grant of two word producers onto one paced MSB-first serial shifter.
module shift_seq_arbiter
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIVW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  input  logic [DIVW-1:0]  div,
  output logic             SO,
  output logic             bit_strobe,
  output logic             frame,
  output logic             grant_id,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  state_t state, state_n;
  logic last_grant, win, accept, msb;
  logic [DIVW-1:0] div_q, tick;
  logic [CW-1:0] bitcnt;
  // Contention goes to whoever did not win last; a lone requester always wins.
  assign win = (req0_valid && req1_valid) ? ~last_grant : (req1_valid ? GRANT_REQ1 : GRANT_REQ0);
  assign req0_ready = (state == IDLE) && req0_valid && (win == GRANT_REQ0);
  assign req1_ready = (state == IDLE) && req1_valid && (win == GRANT_REQ1);
  assign accept = req0_ready || req1_ready;
  assign frame = (state == SHIFT);
  assign done = (state == DONE);
  assign bit_strobe = frame && (tick == div_q);
  assign SO = frame && msb;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = (state == IDLE)  ? (accept ? SHIFT : IDLE) :
              (state == SHIFT) ? ((bit_strobe && bitcnt == '0) ? DONE : SHIFT) : IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      last_grant <= GRANT_REQ1;
      grant_id <= GRANT_REQ0;
      div_q <= '0;
      tick <= '0;
      bitcnt <= '0;
    end else if (accept) begin
      last_grant <= win;
      grant_id <= win;
      div_q <= div;
      tick <= '0;
      bitcnt <= LAST_BIT;
    end else if (frame) begin
      tick <= bit_strobe ? '0 : tick + 1'b1;
      bitcnt <= bit_strobe ? bitcnt - 1'b1 : bitcnt;
    end
  piso_shifter #(.WIDTH(WIDTH)) u_shift (
    .clk(clk),
    .rst(rst),
    .load(accept),
    .data(win ? req1_data : req0_data),
    .en(bit_strobe),
    .sout(msb)
  );
endmodule
